// File: rtl/debug_tap_host_if.sv
// debug_tap_host_if
// Bundles every stream/bus signal of debug_tap_host: the configuration request,
// the host payload link, both directions of the tap port pair, and the capture
// FIFO drain side with its status.
//   master : the debug_tap_host block itself
//   slave  : its environment (host source, tap, capture drain)
// Ports (master view):
//   in  cfg_word[31:0], cfg_start         configuration request
//   in  src_data[31:0], src_valid         host payload
//   out src_stall
//   out tap_in_data[31:0], tap_in_valid   word to tap
//   in  tap_upstream_stall
//   in  tap_out_data[31:0], tap_out_valid debug word from tap
//   out tap_downstream_stall              capture FIFO full
//   out cap_rd_data[31:0], cap_rd_valid   FIFO head
//   in  cap_rd_ready
//   out cap_count[CW-1:0], cap_overflow, drop_count[15:0], busy
interface debug_tap_host_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   cfg_word;
  logic          cfg_start;
  logic [31:0]   src_data;
  logic          src_valid;
  logic          src_stall;
  logic [31:0]   tap_in_data;
  logic          tap_in_valid;
  logic          tap_upstream_stall;
  logic [31:0]   tap_out_data;
  logic          tap_out_valid;
  logic          tap_downstream_stall;
  logic [31:0]   cap_rd_data;
  logic          cap_rd_valid;
  logic          cap_rd_ready;
  logic [CW-1:0] cap_count;
  logic          cap_overflow;
  logic [15:0]   drop_count;
  logic          busy;

  modport master (
    input  cfg_word, cfg_start, src_data, src_valid, tap_upstream_stall,
           tap_out_data, tap_out_valid, cap_rd_ready,
    output src_stall, tap_in_data, tap_in_valid, tap_downstream_stall,
           cap_rd_data, cap_rd_valid, cap_count, cap_overflow, drop_count, busy
  );

  modport slave (
    output cfg_word, cfg_start, src_data, src_valid, tap_upstream_stall,
           tap_out_data, tap_out_valid, cap_rd_ready,
    input  src_stall, tap_in_data, tap_in_valid, tap_downstream_stall,
           cap_rd_data, cap_rd_valid, cap_count, cap_overflow, drop_count, busy
  );
endinterface

// File: rtl/debug_tap_host.sv
// debug_tap_host
// Host-side driver for the debug tap stream port. After reset it sends one
// non-zero configuration word to the tap, then becomes a combinational
// pass-through from the host payload source to the tap. Independently, debug
// words raised by the tap are captured into a first-word-fall-through FIFO;
// words arriving while the FIFO is full are dropped and counted, since the tap
// does not honour stall.
// Ports:
//   clock  system clock, posedge
//   reset  synchronous, active-high
//   bus    debug_tap_host_if.master (see interface header for signal list)
module debug_tap_host #(
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  debug_tap_host_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONF,
    ST_STREAM
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   cfg_q, cfg_d;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_q, drop_d;

  logic          full;
  logic          push;
  logic          pop;
  logic          drop;

  // Configuration / stream state machine
  always_comb begin
    state_d          = state_q;
    cfg_d            = cfg_q;
    bus.src_stall    = 1'b1;
    bus.tap_in_valid = 1'b0;
    bus.tap_in_data  = '0;
    unique case (state_q)
      ST_IDLE: begin
        // A zero word means "unconfigured" to the tap, so it is never sent.
        if (bus.cfg_start && (bus.cfg_word != '0)) begin
          cfg_d   = bus.cfg_word;
          state_d = ST_CONF;
        end
      end
      ST_CONF: begin
        bus.tap_in_valid = 1'b1;
        bus.tap_in_data  = cfg_q;
        if (!bus.tap_upstream_stall) begin
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        // Terminal: the tap only takes configuration once per reset.
        bus.tap_in_data  = bus.src_data;
        bus.tap_in_valid = bus.src_valid;
        bus.src_stall    = bus.tap_upstream_stall;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy = (state_q != ST_IDLE);

  // Capture FIFO control. Full is judged on the pre-pop count, so a push
  // coinciding with a pop while full is still dropped.
  always_comb begin
    full       = (count_q == FULL_COUNT);
    push       = bus.tap_out_valid && !full;
    drop       = bus.tap_out_valid && full;
    pop        = bus.cap_rd_ready && (count_q != '0);
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + CW'(push) - CW'(pop);
    overflow_d = overflow_q | drop;
    drop_d     = drop_q;
    if (drop && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cfg_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Storage is not reset; pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_q] <= bus.tap_out_data;
    end
  end

  // Fall-through head: read is combinational from the read pointer.
  assign bus.cap_rd_data          = mem[rd_ptr_q];
  assign bus.cap_rd_valid         = (count_q != '0);
  assign bus.cap_count            = count_q;
  assign bus.cap_overflow         = overflow_q;
  assign bus.drop_count           = drop_q;
  assign bus.tap_downstream_stall = full;
endmodule

// File: tb/tb_debug_tap_host.sv
// tb_debug_tap_host
// Directed bench for debug_tap_host: a vector table for the configuration and
// pass-through behaviour, plus hand-written sequences for configuration with
// no stall, capture FIFO fill/overflow/wrap, simultaneous push/pop and reset
// in the middle of streaming.
module tb_debug_tap_host;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  debug_tap_host_if #(.DEPTH(16)) bus ();
  debug_tap_host #(.DEPTH(16)) dut (.clock(clock), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        cs;
    logic [31:0] cw;
    logic        sv;
    logic [31:0] sd;
    logic        us;
    logic        e_tv;
    logic [31:0] e_td;
    logic        e_ss;
    logic        e_busy;
  } vec_t;

  vec_t        vecs [20];
  logic [31:0] seen [$];
  logic [31:0] model_q [$];
  int          exp_drop = 0;
  logic        exp_ovf = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic cs, input logic [31:0] cw, input logic sv,
                              input logic [31:0] sd, input logic us, input logic e_tv,
                              input logic [31:0] e_td, input logic e_ss, input logic e_busy);
    vec_t v;
    v.cs = cs; v.cw = cw; v.sv = sv; v.sd = sd; v.us = us;
    v.e_tv = e_tv; v.e_td = e_td; v.e_ss = e_ss; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic check_reset_values(input string tag);
    check32({tag, "_src_stall"}, 32'(bus.src_stall), 32'd1);
    check32({tag, "_tap_in_valid"}, 32'(bus.tap_in_valid), 32'd0);
    check32({tag, "_tap_in_data"}, bus.tap_in_data, 32'd0);
    check32({tag, "_ds_stall"}, 32'(bus.tap_downstream_stall), 32'd0);
    check32({tag, "_rd_valid"}, 32'(bus.cap_rd_valid), 32'd0);
    check32({tag, "_count"}, 32'(bus.cap_count), 32'd0);
    check32({tag, "_overflow"}, 32'(bus.cap_overflow), 32'd0);
    check32({tag, "_drop"}, 32'(bus.drop_count), 32'd0);
    check32({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    #1;
    check_reset_values("reset");
    reset = 1'b0;
    model_q.delete();
    exp_drop = 0;
    exp_ovf  = 1'b0;
  endtask

  // One capture-path cycle with a reference queue model.
  task automatic fifo_cycle(input logic v, input logic [31:0] d, input logic r);
    bit was_full;
    @(negedge clock);
    bus.tap_out_valid = v;
    bus.tap_out_data  = d;
    bus.cap_rd_ready  = r;
    #1;
    if (r && model_q.size() > 0) check32("pop_data", bus.cap_rd_data, model_q[0]);
    was_full = (model_q.size() == 16);
    if (r && model_q.size() > 0) void'(model_q.pop_front());
    if (v) begin
      if (!was_full) model_q.push_back(d);
      else begin
        if (exp_drop < 16'hFFFF) exp_drop++;
        exp_ovf = 1'b1;
      end
    end
    @(posedge clock);
    #1;
    check32("cap_count", 32'(bus.cap_count), model_q.size());
    check32("cap_rd_valid", 32'(bus.cap_rd_valid), 32'(model_q.size() > 0));
    check32("ds_stall", 32'(bus.tap_downstream_stall), 32'(model_q.size() == 16));
    check32("overflow", 32'(bus.cap_overflow), 32'(exp_ovf));
    check32("drop_count", 32'(bus.drop_count), exp_drop);
    $display("fifo v=%0b d=%h r=%0b count=%0d drop=%0d", v, d, r, bus.cap_count, bus.drop_count);
  endtask

  initial begin
    logic [31:0] exp_seen [7];

    bus.cfg_word = '0; bus.cfg_start = 1'b0;
    bus.src_data = '0; bus.src_valid = 1'b0;
    bus.tap_upstream_stall = 1'b0;
    bus.tap_out_data = '0; bus.tap_out_valid = 1'b0;
    bus.cap_rd_ready = 1'b0;

    //               cs  cw          sv  sd          us   tv  td          ss  busy
    vecs[0]  = mk(1, 32'h0,     0, 32'h0,    0,   0, 32'h0,     1, 0); // zero cfg ignored
    vecs[1]  = mk(0, 32'h0,     0, 32'h0,    0,   0, 32'h0,     1, 0);
    vecs[2]  = mk(1, 32'h103,   0, 32'h0,    1,   0, 32'h0,     1, 0); // start config
    vecs[3]  = mk(0, 32'h0,     0, 32'h0,    1,   1, 32'h103,   1, 1); // CONF stalled
    vecs[4]  = mk(0, 32'h0,     0, 32'h0,    1,   1, 32'h103,   1, 1);
    vecs[5]  = mk(0, 32'h0,     0, 32'h0,    1,   1, 32'h103,   1, 1);
    vecs[6]  = mk(0, 32'h0,     0, 32'h0,    0,   1, 32'h103,   1, 1); // accepted
    vecs[7]  = mk(0, 32'h0,     1, 32'hA0,   1,   1, 32'hA0,    1, 1); // STREAM
    vecs[8]  = mk(0, 32'h0,     1, 32'hA0,   0,   1, 32'hA0,    0, 1);
    vecs[9]  = mk(0, 32'h0,     1, 32'hA1,   1,   1, 32'hA1,    1, 1);
    vecs[10] = mk(0, 32'h0,     1, 32'hA1,   0,   1, 32'hA1,    0, 1);
    vecs[11] = mk(0, 32'h0,     1, 32'hA2,   1,   1, 32'hA2,    1, 1);
    vecs[12] = mk(0, 32'h0,     1, 32'hA2,   0,   1, 32'hA2,    0, 1);
    vecs[13] = mk(0, 32'h0,     1, 32'hA3,   1,   1, 32'hA3,    1, 1);
    vecs[14] = mk(0, 32'h0,     1, 32'hA3,   0,   1, 32'hA3,    0, 1);
    vecs[15] = mk(0, 32'h0,     1, 32'hA4,   1,   1, 32'hA4,    1, 1);
    vecs[16] = mk(0, 32'h0,     1, 32'hA4,   0,   1, 32'hA4,    0, 1);
    vecs[17] = mk(0, 32'h0,     0, 32'h0,    0,   0, 32'h0,     0, 1);
    vecs[18] = mk(1, 32'h55,    0, 32'h0,    1,   0, 32'h0,     1, 1); // cfg in STREAM ignored
    vecs[19] = mk(0, 32'h0,     1, 32'hBEEF, 0,   1, 32'hBEEF,  0, 1);

    exp_seen[0] = 32'h103; exp_seen[1] = 32'hA0; exp_seen[2] = 32'hA1;
    exp_seen[3] = 32'hA2;  exp_seen[4] = 32'hA3; exp_seen[5] = 32'hA4;
    exp_seen[6] = 32'hBEEF;

    // Reset then configure with no stall: exactly one cycle of config word.
    do_reset();
    @(negedge clock);
    bus.cfg_word = 32'h0000_0103; bus.cfg_start = 1'b1;
    #1;
    check32("cfg0_tv_idle", 32'(bus.tap_in_valid), 32'd0);
    @(negedge clock);
    bus.cfg_start = 1'b0; bus.cfg_word = '0;
    #1;
    check32("cfg0_tv_conf", 32'(bus.tap_in_valid), 32'd1);
    check32("cfg0_td_conf", bus.tap_in_data, 32'h0000_0103);
    check32("cfg0_busy_conf", 32'(bus.busy), 32'd1);
    @(negedge clock);
    #1;
    check32("cfg0_tv_stream", 32'(bus.tap_in_valid), 32'd0);
    check32("cfg0_ss_stream", 32'(bus.src_stall), 32'd0);
    check32("cfg0_busy_stream", 32'(bus.busy), 32'd1);
    $display("config no-stall sequence done");

    // Table: zero config, CONF under stall, payload with toggling stall.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      bus.cfg_start = vecs[i].cs; bus.cfg_word = vecs[i].cw;
      bus.src_valid = vecs[i].sv; bus.src_data = vecs[i].sd;
      bus.tap_upstream_stall = vecs[i].us;
      #1;
      check32($sformatf("vec%0d_tv", i), 32'(bus.tap_in_valid), 32'(vecs[i].e_tv));
      if (vecs[i].e_tv) check32($sformatf("vec%0d_td", i), bus.tap_in_data, vecs[i].e_td);
      check32($sformatf("vec%0d_ss", i), 32'(bus.src_stall), 32'(vecs[i].e_ss));
      check32($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vecs[i].e_busy));
      if (bus.tap_in_valid && !bus.tap_upstream_stall) seen.push_back(bus.tap_in_data);
      $display("vec %0d tv=%0b td=%h ss=%0b busy=%0b", i, bus.tap_in_valid, bus.tap_in_data,
               bus.src_stall, bus.busy);
    end
    @(negedge clock);
    bus.cfg_start = 1'b0; bus.cfg_word = '0;
    bus.src_valid = 1'b0; bus.src_data = '0; bus.tap_upstream_stall = 1'b0;
    check32("tap_seen_len", seen.size(), 32'd7);
    for (int i = 0; i < 7; i++) begin
      if (i < seen.size()) check32($sformatf("tap_seen%0d", i), seen[i], exp_seen[i]);
    end

    // Capture path: offset pointers, push+pop at 5, fill/overflow, push+pop at 16.
    for (int i = 0; i < 5; i++) fifo_cycle(1'b1, 32'hC0 + 32'(i), 1'b0);
    fifo_cycle(1'b1, 32'hC5, 1'b1);
    check32("count_at5_pushpop", 32'(bus.cap_count), 32'd5);
    for (int i = 0; i < 6; i++) fifo_cycle(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 18; i++) fifo_cycle(1'b1, 32'hD0 + 32'(i), 1'b0);
    check32("fill_count", 32'(bus.cap_count), 32'd16);
    check32("fill_ds_stall", 32'(bus.tap_downstream_stall), 32'd1);
    check32("fill_drop", 32'(bus.drop_count), 32'd2);
    check32("fill_overflow", 32'(bus.cap_overflow), 32'd1);
    fifo_cycle(1'b1, 32'hEE, 1'b1);
    check32("full_pushpop_count", 32'(bus.cap_count), 32'd15);
    check32("full_pushpop_drop", 32'(bus.drop_count), 32'd3);
    for (int i = 0; i < 15; i++) fifo_cycle(1'b0, 32'h0, 1'b1);
    check32("drained_count", 32'(bus.cap_count), 32'd0);
    fifo_cycle(1'b1, 32'h77, 1'b0);

    // Reset while streaming: outputs at reset values after one edge.
    @(negedge clock);
    bus.src_valid = 1'b1; bus.src_data = 32'h1234; bus.tap_upstream_stall = 1'b0;
    bus.tap_out_valid = 1'b1; bus.tap_out_data = 32'h99; bus.cap_rd_ready = 1'b0;
    #1;
    check32("pre_reset_tv", 32'(bus.tap_in_valid), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    #1;
    check_reset_values("midreset");
    reset = 1'b0;
    bus.tap_out_valid = 1'b0; bus.src_valid = 1'b0;
    $display("mid-stream reset sequence done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/debug_tap_host.md
# debug_tap_host

Host-side counterpart of the debug tap stream port on the DE1SOC adapter. It configures the tap by sending the single configuration word the tap latches after reset, then forwards the payload stream into the tap. It also captures the debug words the tap raises into a first-word-fall-through FIFO that software or a bench can drain. It sits between the host streaming source and the tap's `in_*/out_*/stall` port pair.

## Interface
- `DEPTH`, 16, capture FIFO depth in 32-bit words; must be a power of 2 and ≥ 2.
- `CW`, `$clog2(DEPTH)+1`, width of `cap_count`; derived, not overridden.

Ports:
- `clock`  in  1  system clock, all logic on posedge.
- `reset`  in  1  synchronous, active-high; the tap shares this reset.
- `cfg_word`  in  32  configuration word: `[31:8]` condition mask, `[7:0]` signal select.
- `cfg_start`  in  1  one-cycle request to send `cfg_word`.
- `src_data`  in  32  payload word from host.
- `src_valid`  in  1  payload word valid.
- `src_stall`  out  1  host must hold the payload word.
- `tap_in_data`  out  32  word to tap.
- `tap_in_valid`  out  1  word to tap valid.
- `tap_upstream_stall`  in  1  tap cannot accept a word.
- `tap_out_data`  in  32  debug word from tap.
- `tap_out_valid`  in  1  debug word valid.
- `tap_downstream_stall`  out  1  capture FIFO full.
- `cap_rd_data`  out  32  FIFO head word.
- `cap_rd_valid`  out  1  FIFO non-empty.
- `cap_rd_ready`  in  1  pop the head word.
- `cap_count`  out  CW  FIFO occupancy, 0..DEPTH.
- `cap_overflow`  out  1  sticky: at least one debug word was dropped.
- `drop_count`  out  16  dropped-word count, saturating at 16'hFFFF.
- `busy`  out  1  high in the CONF and STREAM states.

## Operation
Transfer rule on every stream link: a word moves in a cycle where `valid=1` and `stall=0`, both sampled at the same posedge.

The state machine has three states: IDLE, CONF and STREAM.
- **IDLE**
  - `src_stall=1`, `tap_in_valid=0`.
  - `cfg_start=1` with `cfg_word!=0` latches `cfg_word` into `cfg_q` and moves to CONF.
  - `cfg_start` with `cfg_word==0` is ignored, because the tap treats 0 as unconfigured.
- **CONF**
  - `tap_in_valid=1`, `tap_in_data=cfg_q`, `src_stall=1`.
  - When `tap_upstream_stall=0`, the word is accepted and the block moves to STREAM.
  - Otherwise it holds `cfg_q` unchanged.
- **STREAM** is a combinational pass-through:
  - `tap_in_data=src_data`
  - `tap_in_valid=src_valid`
  - `src_stall=tap_upstream_stall`
- STREAM is terminal; only `reset` returns to IDLE, because the tap accepts configuration once per reset.
- `cfg_start` in CONF or STREAM is ignored.

Capture path (active in all states):
- Push: `tap_out_valid=1` and `cap_count<DEPTH` writes `tap_out_data` at the write pointer.
- Drop: `tap_out_valid=1` and `cap_count==DEPTH`.
  - The word is discarded.
  - `cap_overflow` is set.
  - `drop_count` increments, saturating.
  - The tap does not honour stall, so drops are expected and must be counted.
- Pop: `cap_rd_ready=1` and `cap_rd_valid=1` advances the read pointer.
- Full is judged on the pre-pop count. A push in the same cycle as a pop while full is dropped, even though a slot frees that cycle.
- Push and pop in the same cycle when not full: `cap_count` is unchanged and both pointers advance.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally from DEPTH-1 to 0.
- `tap_downstream_stall = (cap_count==DEPTH)`, decoded from the registered count.
- `cap_rd_data` = memory at the read pointer, first-word-fall-through. It is undefined when `cap_rd_valid=0`.

## Timing
Reset values:
- state IDLE
- `src_stall=1`
- `tap_in_valid=0`, `tap_in_data=0`
- `tap_downstream_stall=0`
- `cap_rd_valid=0`, `cap_count=0`
- `cap_overflow=0`, `drop_count=0`
- `busy=0`

FIFO memory contents are not reset.

Latencies:
- `cfg_start` to `tap_in_valid=1` (CONF): 1 cycle.
- CONF accept to STREAM: the next cycle.
- STREAM pass-through: 0 cycles, purely combinational.
- Push to `cap_rd_valid=1` and `cap_count` update: 1 cycle.
- Pop to count decrement: 1 cycle.
- Drop to `cap_overflow` and `drop_count` update: 1 cycle.

Reset mid-operation:
- In CONF, the pending configuration is abandoned.
- In STREAM, pass-through stops and `src_stall=1` on the cycle after reset.
- FIFO contents are discarded and counters cleared.

## Test plan
- **Reset then configure.** Reset 2 cycles; `cfg_word=32'h0000_0103`, `cfg_start` 1 cycle, `tap_upstream_stall=0`.
  - Required: `tap_in_valid=1` with data 32'h0000_0103 for exactly 1 cycle, then STREAM, `busy=1`.
- **Zero configuration ignored.** `cfg_start` with `cfg_word=0`.
  - Required: remains IDLE, `tap_in_valid=0`, `src_stall=1`.
- **CONF under stall.** Hold `tap_upstream_stall=1` for 3 cycles.
  - Required: config word held stable 4 cycles and accepted on the 4th.
- **Payload pass-through.** Send 32'hA0..32'hA4 with `tap_upstream_stall` toggling every cycle.
  - Required: the tap sees exactly A0..A4 in order with no duplicates.
- **Fill and overflow.** With DEPTH=16, push 18 debug words with no pops.
  - Required: `cap_count=16`, `tap_downstream_stall=1`, `drop_count=2`, `cap_overflow=1`.
  - Draining returns the first 16 words in order, with wrap verified.
- **Push and pop together, plus reset.**
  - Simultaneous push and pop at count 5: count stays 5.
  - Simultaneous push and pop at count 16: count becomes 15 and `drop_count` increments.
  - Reset mid-STREAM: all outputs return to reset values the next cycle.
